// File: rtl/registers_bank.sv
// Multi-ported register file: one synchronous write port, two combinational read ports.
// Synchronous active-high reset clears every register and overrides a same-edge write.
module registers_bank #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  clock,
  input  logic                  regwrite,
  input  logic [ADDR_WIDTH-1:0] reg1_read,
  input  logic [ADDR_WIDTH-1:0] reg2_read,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] writedata,
  output logic [DATA_WIDTH-1:0] data1,
  output logic [DATA_WIDTH-1:0] data2,
  input  logic                  reset
);

  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NumRegs];
  logic [DATA_WIDTH-1:0] regs_d [NumRegs];

  always_comb begin
    regs_d = regs_q;
    if (reset) begin
      for (int i = 0; i < int'(NumRegs); i++) begin
        regs_d[i] = '0;
      end
    end else if (regwrite) begin
      regs_d[address] = writedata;
    end
  end

  always_ff @(posedge clock) begin
    regs_q <= regs_d;
  end

  // Reads come straight from storage: no bypass of the write in flight.
  assign data1 = regs_q[reg1_read];
  assign data2 = regs_q[reg2_read];

endmodule

// File: tb/tb_registers_bank.sv
// Self-checking bench for registers_bank: directed scenarios plus randomized traffic
// compared against a simple array model of the register file.
module tb_registers_bank;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 2;
  localparam int unsigned N  = 2 ** AW;

  logic          clock;
  logic          regwrite;
  logic [AW-1:0] reg1_read;
  logic [AW-1:0] reg2_read;
  logic [AW-1:0] address;
  logic [DW-1:0] writedata;
  logic [DW-1:0] data1;
  logic [DW-1:0] data2;
  logic          reset;

  logic [DW-1:0] model [N];
  int checks;
  int failures;

  registers_bank #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clock    (clock),
    .regwrite (regwrite),
    .reg1_read(reg1_read),
    .reg2_read(reg2_read),
    .address  (address),
    .writedata(writedata),
    .data1    (data1),
    .data2    (data2),
    .reset    (reset)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One rising edge; the model applies the register-file rules to the inputs seen at the edge.
  task automatic tick();
    logic          r;
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    @(posedge clock);
    r = reset;
    w = regwrite;
    a = address;
    d = writedata;
    if (r) begin
      for (int i = 0; i < int'(N); i++) model[i] = '0;
    end else if (w) begin
      model[a] = d;
    end
    #1;
  endtask

  task automatic sweep_reads(input string tag);
    for (int i = 0; i < int'(N); i++) begin
      reg1_read = AW'(i);
      reg2_read = AW'(N - 1 - i);
      #1;
      check_eq({tag, "_d1"}, data1, model[i]);
      check_eq({tag, "_d2"}, data2, model[N - 1 - i]);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    regwrite  = 1'b0;
    reg1_read = '0;
    reg2_read = '0;
    address   = '0;
    writedata = '0;
    reset     = 1'b1;
    for (int i = 0; i < int'(N); i++) model[i] = 'x;

    @(negedge clock);
    tick();
    reset = 1'b0;
    sweep_reads("reset_zero");

    // Two writes, then read both ports back
    @(negedge clock);
    address = 0; writedata = 8'hAA; regwrite = 1'b1;
    tick();
    @(negedge clock);
    address = 1; writedata = 8'h55;
    tick();
    @(negedge clock);
    regwrite = 1'b0;
    reg1_read = 0; reg2_read = 1; #1;
    check_eq("wr_d1_r0", data1, 8'hAA);
    check_eq("wr_d2_r1", data2, 8'h55);
    reg1_read = 1; reg2_read = 0; #1;
    check_eq("wr_d1_r1", data1, 8'h55);
    check_eq("wr_d2_r0", data2, 8'hAA);
    reg1_read = 2; reg2_read = 3; #1;
    check_eq("wr_d1_r2", data1, 8'h00);
    check_eq("wr_d2_r3", data2, 8'h00);

    // Same index on both ports
    reg1_read = 1; reg2_read = 1; #1;
    check_eq("same_d1", data1, 8'h55);
    check_eq("same_d2", data2, 8'h55);

    // No bypass: old value before the edge, new value right after
    @(negedge clock);
    reg1_read = 2; address = 2; writedata = 8'h3C; regwrite = 1'b1; #1;
    check_eq("nobypass_pre", data1, 8'h00);
    tick();
    check_eq("nobypass_post", data1, 8'h3C);

    // Write disabled across several edges
    @(negedge clock);
    regwrite = 1'b0; address = 3; writedata = 8'hFF; reg2_read = 3;
    repeat (3) tick();
    check_eq("wr_disabled", data2, 8'h00);

    // Between-edge wiggles of write inputs and reset must not change state
    @(negedge clock);
    regwrite = 1'b1; address = 0; writedata = 8'h11; #1;
    regwrite = 1'b0; reset = 1'b1; reg1_read = 0; #1;
    check_eq("midcycle_hold", data1, 8'hAA);
    reset = 1'b0;
    tick();
    check_eq("midcycle_after", data1, 8'hAA);

    // Load nonzero everywhere, then reset wins over a simultaneous write
    for (int i = 0; i < int'(N); i++) begin
      @(negedge clock);
      address = AW'(i); writedata = DW'(8'h90 + i); regwrite = 1'b1;
      tick();
    end
    @(negedge clock);
    regwrite = 1'b0;
    sweep_reads("loaded");
    @(negedge clock);
    reset = 1'b1; regwrite = 1'b1; address = 0; writedata = 8'h77;
    tick();
    @(negedge clock);
    regwrite = 1'b0;
    sweep_reads("reset_prio");
    for (int i = 0; i < int'(N); i++) begin
      reg1_read = AW'(i); #1;
      check_eq("reset_prio_const", data1, 8'h00);
    end
    reset = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 300; c++) begin
      @(negedge clock);
      reset     = ($urandom_range(0, 19) == 0);
      regwrite  = $urandom_range(0, 1) == 1;
      address   = AW'($urandom_range(0, N - 1));
      writedata = DW'($urandom);
      reg1_read = AW'($urandom_range(0, N - 1));
      reg2_read = AW'($urandom_range(0, N - 1));
      #1;
      check_eq("rnd_pre_d1", data1, model[reg1_read]);
      check_eq("rnd_pre_d2", data2, model[reg2_read]);
      tick();
      check_eq("rnd_post_d1", data1, model[reg1_read]);
      check_eq("rnd_post_d2", data2, model[reg2_read]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/registers_bank.md
REGISTERS_BANK -- requirements
Module: registers_bank

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of each register and of the data ports.
REQ-002 Parameter ADDR_WIDTH, default 2, width of each register index; register count SHALL be 2**ADDR_WIDTH (4 by default).
REQ-003 Port order SHALL be: clock, regwrite, reg1_read, reg2_read, address, writedata, data1, data2, reset.
REQ-004 clock  input  1  single clock; all state changes SHALL occur on its rising edge.
REQ-005 reset  input  1  reset is synchronous and active-high.
REQ-006 regwrite  input  1  write enable; high SHALL commit writedata on the next rising clock edge.
REQ-007 reg1_read  input  ADDR_WIDTH  index of register driven onto data1.
REQ-008 reg2_read  input  ADDR_WIDTH  index of register driven onto data2.
REQ-009 address  input  ADDR_WIDTH  index of register written when regwrite is high.
REQ-010 writedata  input  DATA_WIDTH  value to write.
REQ-011 data1  output  DATA_WIDTH  contents of register reg1_read.
REQ-012 data2  output  DATA_WIDTH  contents of register reg2_read.

Function
REQ-013 Storage SHALL be 2**ADDR_WIDTH independent registers of DATA_WIDTH bits each; no register SHALL be hard-wired to a constant.
REQ-014 Write: on a rising clock edge with reset=0 and regwrite=1, register[address] SHALL take writedata; all other registers SHALL hold.
REQ-015 With regwrite=0 and reset=0, no register SHALL change on any edge.
REQ-016 Reads SHALL be combinational: data1/data2 SHALL follow reg1_read/reg2_read and register contents with zero clock latency.
REQ-017 The two read ports SHALL be independent; equal indices SHALL yield identical values on data1 and data2.
REQ-018 No write-through bypass: when reading the register being written, data1/data2 SHALL show the old value until the rising edge, then the new value immediately after it.
REQ-019 writedata, address and regwrite SHALL be sampled only at the rising edge; changes between edges SHALL have no effect on state.
REQ-020 All index values 0..2**ADDR_WIDTH-1 SHALL be valid; no out-of-range case exists.
REQ-021 Read ports SHALL remain functional during reset; they SHALL reflect register contents (all zero once the reset edge has occurred).

Reset
REQ-022 On a rising clock edge with reset=1, every register SHALL become 0.
REQ-023 Reset SHALL take priority over a simultaneous write; regwrite=1 during a reset edge SHALL leave the target register at 0.
REQ-024 Assertion of reset between edges SHALL not change state until the next rising edge.
REQ-025 Before the first reset edge, register contents are undefined; no initial value is required.

Verification
REQ-026 reset=1 for one edge, then reg1_read=0..3 and reg2_read=0..3 swept -> data1 = data2 = 8'h00 for every index.
REQ-027 reset=0, address=0, writedata=8'hAA, regwrite=1 for one edge; then address=1, writedata=8'h55, regwrite=1 for one edge; regwrite=0 -> reg1_read=0 gives data1=8'hAA, reg1_read=1 gives data1=8'h55, reg2_read=0 gives data2=8'hAA, reg2_read=1 gives data2=8'h55, registers 2 and 3 read 8'h00.
REQ-028 reg1_read=2 held, address=2, writedata=8'h3C, regwrite=1 -> data1 keeps the old value before the edge and reads 8'h3C immediately after it.
REQ-029 regwrite=0, address=3, writedata=8'hFF across several edges -> register 3 reads unchanged 8'h00.
REQ-030 Registers loaded with nonzero values, then reset=1 and regwrite=1 with address=0, writedata=8'h77 on the same edge -> all four registers read 8'h00.
REQ-031 reg1_read=reg2_read=1 after register 1 holds 8'h55 -> data1 = data2 = 8'h55.
